// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery multiplier: FSM encoding and mode constants.
package mont_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FINAL = 2'd2
   } state_t;

   localparam logic MODE_MA  = 1'b0;
   localparam logic MODE_PRE = 1'b1;

endpackage

// File: rtl/mont_csub.sv
// Compare-and-subtract: diff = x - y, ge = (x >= y) taken from the borrow-out.
module mont_csub #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] diff,
   output logic         ge
);

   logic [W:0] d;

   assign d    = {1'b0, x} - {1'b0, y};
   assign diff = d[W-1:0];
   assign ge   = ~d[W];

endmodule

// File: rtl/mont_mul_param.sv
// Iterative radix-2 Montgomery multiplier (mode 0) and A*2^WIDTH mod N pre-processing (mode 1).
module mont_mul_param
   import mont_pkg::*;
#(
   parameter int WIDTH = 256,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int AW = WIDTH + 2;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             mode_q;
   logic [WIDTH-1:0] a_q, b_q, n_q;
   logic [AW-1:0]    acc;
   logic [AW-1:0]    b_ext, n_ext;
   logic [AW-1:0]    v_add, v_sum, v_nxt;
   logic [AW-1:0]    cs_in, cs_diff;
   logic             cs_ge;
   logic             last;

   assign b_ext = {2'b00, b_q};
   assign n_ext = {2'b00, n_q};
   assign last  = (cnt == CNT_W'(WIDTH - 1));

   // Montgomery step: add a_i*B, make even by adding N, halve.
   assign v_add = acc + (a_q[0] ? b_ext : '0);
   assign v_sum = v_add + (v_add[0] ? n_ext : '0);
   assign v_nxt = v_sum >> 1;

   // One compare-subtract serves both the doubling step in RUN and the final reduction.
   assign cs_in = (state == RUN) ? {acc[AW-2:0], 1'b0} : acc;

   mont_csub #(.W(AW)) u_csub (
      .x    (cs_in),
      .y    (n_ext),
      .diff (cs_diff),
      .ge   (cs_ge)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = FINAL;
         FINAL:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // done keeps busy high through the pulse cycle even though the FSM is already IDLE.
   always_comb begin
      busy = (state != IDLE) || done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         acc    <= '0;
         done   <= 1'b0;
         result <= '0;
         mode_q <= MODE_MA;
         a_q    <= '0;
         b_q    <= '0;
         n_q    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  a_q    <= a;
                  b_q    <= b;
                  n_q    <= n;
                  cnt    <= '0;
                  acc    <= (mode == MODE_PRE) ? {2'b00, a} : '0;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               a_q <= a_q >> 1;
               if (mode_q == MODE_PRE) acc <= cs_ge ? cs_diff : cs_in;
               else                    acc <= v_nxt;
            end
            FINAL: begin
               done   <= 1'b1;
               result <= cs_ge ? cs_diff[WIDTH-1:0] : acc[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_mul_param.sv
// Scoreboard bench: WIDTH=8 and WIDTH=256 instances checked against a modular-arithmetic model.
module tb_mont_mul_param;

   logic clk, rst;
   logic start8, mode8, busy8, done8;
   logic [7:0] a8, b8, n8, result8;
   logic start256, mode256, busy256, done256;
   logic [255:0] a256, b256, n256, result256;

   int tests = 0;
   int fails = 0;
   int edge_cnt = 0;

   typedef struct {
      logic [255:0] res;
      int           due;
   } exp_t;

   exp_t q8[$];
   exp_t q256[$];

   mont_mul_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8), .n(n8),
      .busy(busy8), .done(done8), .result(result8)
   );

   mont_mul_param #(.WIDTH(256)) dut256 (
      .clk(clk), .rst(rst), .start(start256), .mode(mode256), .a(a256), .b(b256), .n(n256),
      .busy(busy256), .done(done256), .result(result256)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Reference: mode 0 = a*b*(2^-w) mod n using inverse of 2 = (n+1)/2; mode 1 = a*2^w mod n.
   function automatic logic [255:0] ref_model(input int w, input logic md,
                                             input logic [255:0] av, bv, nv);
      logic [511:0] a5, b5, n5, r, h, ri;
      a5 = {256'd0, av};
      b5 = {256'd0, bv};
      n5 = {256'd0, nv};
      if (md) begin
         r = (a5 << w) % n5;
      end else begin
         h  = (n5 + 512'd1) >> 1;
         ri = 512'd1;
         for (int i = 0; i < w; i++) ri = (ri * h) % n5;
         r = (((a5 * b5) % n5) * ri) % n5;
      end
      return r[255:0];
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) begin
            chk("done8_unexpected", 256'(done8), 256'd0);
         end else begin
            e = q8.pop_front();
            chk("result8", {248'd0, result8}, e.res);
            chk("done8_cycle", 256'(edge_cnt), 256'(e.due));
         end
      end
      if (done256) begin
         if (q256.size() == 0) begin
            chk("done256_unexpected", 256'(done256), 256'd0);
         end else begin
            e = q256.pop_front();
            chk("result256", result256, e.res);
            chk("done256_cycle", 256'(edge_cnt), 256'(e.due));
         end
      end
   end

   // Called just after a negedge; returns just after a negedge.
   task automatic op(input bit big, input logic md, input logic [255:0] av, bv, nv,
                     input logic [255:0] expv);
      int guard = 0;
      int k;
      while ((big ? (busy256 && !done256) : (busy8 && !done8)) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) chk("op_wait_timeout", 256'(guard), 256'd0);
      if (big) begin
         start256 = 1'b1; mode256 = md; a256 = av; b256 = bv; n256 = nv;
      end else begin
         start8 = 1'b1; mode8 = md; a8 = av[7:0]; b8 = bv[7:0]; n8 = nv[7:0];
      end
      @(posedge clk);
      #1;
      k = edge_cnt;
      if (big) begin
         start256 = 1'b0; mode256 = ~md; a256 = rnd256(); b256 = rnd256(); n256 = rnd256();
         q256.push_back('{expv, k + 257});
      end else begin
         start8 = 1'b0; mode8 = ~md; a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom);
         q8.push_back('{expv, k + 9});
      end
      @(negedge clk);
      chk(big ? "busy256_after_start" : "busy8_after_start",
          256'(big ? busy256 : busy8), 256'd1);
   endtask

   task automatic drain();
      int guard = 0;
      while ((q8.size() != 0 || q256.size() != 0) && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_timeout", 256'(q8.size() + q256.size()), 256'd0);
      @(negedge clk);
   endtask

   initial begin
      logic [255:0] av, bv, nv, rr;
      logic [7:0] n_s;
      logic md;
      int k;

      rst = 1'b1;
      start8 = 0; mode8 = 0; a8 = 0; b8 = 0; n8 = 0;
      start256 = 0; mode256 = 0; a256 = 0; b256 = 0; n256 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy8", 256'(busy8), 256'd0);
      chk("rst_done8", 256'(done8), 256'd0);
      chk("rst_result8", 256'(result8), 256'd0);
      chk("rst_busy256", 256'(busy256), 256'd0);
      chk("rst_done256", 256'(done256), 256'd0);
      chk("rst_result256", result256, 256'd0);
      rst = 1'b0;

      // First edge with rst low accepts start; then back-to-back known vectors.
      op(0, 0, 5, 7, 13, 1);
      op(0, 1, 5, 0, 13, 6);
      op(0, 0, 12, 12, 13, 3);
      op(0, 0, 0, 7, 13, 0);

      for (int i = 0; i < 60; i++) begin
         n_s = 8'($urandom_range(3, 255)) | 8'd1;
         av = 256'($urandom % n_s);
         bv = 256'($urandom % n_s);
         md = 1'($urandom);
         op(0, md, av, bv, {248'd0, n_s}, ref_model(8, md, av, bv, {248'd0, n_s}));
      end
      drain();

      // start held high: accepted every WIDTH+2 edges, ignored while busy.
      start8 = 1'b1; mode8 = 0; a8 = 5; b8 = 7; n8 = 13;
      @(posedge clk);
      #1;
      k = edge_cnt;
      q8.push_back('{256'd1, k + 9});
      q8.push_back('{256'd1, k + 19});
      q8.push_back('{256'd1, k + 29});
      repeat (20) @(posedge clk);
      #1;
      start8 = 1'b0;
      drain();

      // Abort in the fourth RUN cycle: no done pulse, outputs cleared.
      start8 = 1'b1; mode8 = 0; a8 = 5; b8 = 7; n8 = 13;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy8", 256'(busy8), 256'd0);
      chk("abort_done8", 256'(done8), 256'd0);
      chk("abort_result8", 256'(result8), 256'd0);
      repeat (20) @(negedge clk);
      chk("abort_result8_hold", 256'(result8), 256'd0);
      op(0, 0, 5, 7, 13, 1);
      drain();

      // a=1, b=R^2 mod n yields R mod n.
      for (int i = 0; i < 4; i++) begin
         nv = rnd256() | 256'd1 | {1'b1, 255'd0};
         rr = 256'(((512'd1 << 256) % {256'd0, nv}));
         bv = 256'((({256'd0, rr} * {256'd0, rr}) % {256'd0, nv}));
         op(1, 0, 256'd1, bv, nv, rr);
      end
      for (int i = 0; i < 60; i++) begin
         nv = rnd256() | 256'd1;
         if (nv < 256'd3) nv = 256'd3;
         av = rnd256() % nv;
         bv = rnd256() % nv;
         md = 1'(i & 1);
         op(1, md, av, bv, nv, ref_model(256, md, av, bv, nv));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
